// File: rtl/extend_pkg.sv
// Shared definitions for the immediate extender: ImmSrc encoding and bus widths.
// Optional registered output is enabled with the EXTEND_REG_EN macro.
package extend_pkg;

  localparam int INSTR_W_DEF = 18;
  localparam int DATA_W_DEF  = 32;
  localparam int IMM13_W     = 13;

  typedef enum logic [1:0] {
    IMM_ZE13   = 2'b00,
    IMM_SE13   = 2'b01,
    IMM_SE18S2 = 2'b10,
    IMM_RSVD   = 2'b11
  } imm_src_e;

endpackage

// File: rtl/extend_core.sv
// Combinational immediate decode: ImmSrc/Instr -> ExtImm/ImmErr, zero latency, no state.
// An unknown ImmSrc drives unknown outputs so upstream X problems stay visible.
module extend_core
  import extend_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic [1:0]         ImmSrc,
  input  logic [INSTR_W-1:0] Instr,
  output logic [DATA_W-1:0]  ExtImm,
  output logic               ImmErr
);

  always_comb begin
    ExtImm = '0;
    ImmErr = 1'b0;
    case (ImmSrc)
      IMM_ZE13:   ExtImm = {{(DATA_W-IMM13_W){1'b0}}, Instr[IMM13_W-1:0]};
      IMM_SE13:   ExtImm = {{(DATA_W-IMM13_W){Instr[IMM13_W-1]}}, Instr[IMM13_W-1:0]};
      // word-aligned branch offset: scale by 4, sign from the top field bit
      IMM_SE18S2: ExtImm = {{(DATA_W-INSTR_W-2){Instr[INSTR_W-1]}}, Instr, 2'b00};
      IMM_RSVD:   ImmErr = 1'b1;
      default: begin
        ExtImm = 'x;
        ImmErr = 1'bx;
      end
    endcase
  end

endmodule

// File: rtl/extend.sv
// Immediate extender top: combinational decode plus sticky error flag and,
// with EXTEND_REG_EN defined, a one-cycle registered copy ExtImmQ.
module extend
  import extend_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         ImmSrc,
  input  logic [INSTR_W-1:0] Instr,
  output logic [DATA_W-1:0]  ExtImm,
  output logic               ImmErr,
  output logic               ErrSticky
`ifdef EXTEND_REG_EN
  ,
  output logic [DATA_W-1:0]  ExtImmQ
`endif
);

  extend_core #(
    .INSTR_W(INSTR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .ImmSrc(ImmSrc),
    .Instr (Instr),
    .ExtImm(ExtImm),
    .ImmErr(ImmErr)
  );

  // only reset clears the error record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ErrSticky <= 1'b0;
    end else if (ImmErr) begin
      ErrSticky <= 1'b1;
    end
  end

`ifdef EXTEND_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ExtImmQ <= '0;
    end else begin
      ExtImmQ <= ExtImm;
    end
  end
`endif

endmodule

// File: tb/tb_extend.sv
// Scoreboard bench for extend: stimulus pushes expectations, a monitor compares on negedge.
module tb_extend;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ImmSrc;
  logic [17:0] Instr;
  logic [31:0] ExtImm;
  logic        ImmErr;
  logic        ErrSticky;
`ifdef EXTEND_REG_EN
  logic [31:0] ExtImmQ;
`endif

  extend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ImmSrc   (ImmSrc),
    .Instr    (Instr),
    .ExtImm   (ExtImm),
    .ImmErr   (ImmErr),
    .ErrSticky(ErrSticky)
`ifdef EXTEND_REG_EN
    ,
    .ExtImmQ  (ExtImmQ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ext;
    logic        err;
    logic        sticky;
    logic [31:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic        sticky_m = 1'b0;
  logic [31:0] prev_ext = 32'h0;

  // Reference: interpret the field as an integer and apply the mode rule arithmetically.
  function automatic logic [31:0] ref_ext(input logic [1:0] s, input logic [17:0] i);
    int v;
    case (s)
      2'd0: v = int'(i) % 8192;
      2'd1: begin
        v = int'(i) % 8192;
        if (v >= 4096) v = v - 8192;
      end
      2'd2: begin
        v = int'(i);
        if (v >= 131072) v = v - 262144;
        v = v * 4;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Apply a vector after a rising edge, record what must be visible before the next edge.
  task automatic issue(input string nm, input logic [1:0] s, input logic [17:0] i,
                       input logic rv, input logic [31:0] ext_req);
    exp_t e;
    ImmSrc = s;
    Instr  = i;
    rst_n  = rv;
    if (!rv) begin
      sticky_m = 1'b0;
      prev_ext = 32'h0;
    end
    e.name   = nm;
    e.ext    = ext_req;
    e.err    = (s == 2'b11);
    e.sticky = sticky_m;
    e.q      = prev_ext;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (s == 2'b11) sticky_m = 1'b1;
      prev_ext = ext_req;
    end
    #2;
  endtask

  task automatic issue_m(input string nm, input logic [1:0] s, input logic [17:0] i,
                         input logic rv);
    issue(nm, s, i, rv, ref_ext(s, i));
  endtask

  // Monitor: outputs are combinational or registered, so each negedge presents one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".ExtImm"}, ExtImm, e.ext);
        check({e.name, ".ImmErr"}, {31'b0, ImmErr}, {31'b0, e.err});
        check({e.name, ".ErrSticky"}, {31'b0, ErrSticky}, {31'b0, e.sticky});
`ifdef EXTEND_REG_EN
        check({e.name, ".ExtImmQ"}, ExtImmQ, e.q);
`endif
      end
    end
  end

  initial begin
    logic [1:0]  s;
    logic [17:0] i;
    logic        rv;
    rst_n  = 1'b0;
    ImmSrc = 2'b00;
    Instr  = 18'h0;
    @(posedge clk);
    #2;
    issue("reset_state", 2'b00, 18'h00000, 1'b0, 32'h00000000);
    issue("ze13_a", 2'b00, 18'b111100001111000011, 1'b1, 32'h000003C3);
    issue("ze13_b", 2'b00, 18'h3FFFF,              1'b1, 32'h00001FFF);
    issue("se13_a", 2'b01, 18'b111100001111000011, 1'b1, 32'h000003C3);
    issue("se13_b", 2'b01, 18'h3FFFF,              1'b1, 32'hFFFFFFFF);
    issue("se13_q", 2'b00, 18'h00000,              1'b1, 32'h00000000);
    issue("se18_a", 2'b10, 18'b001100001111000011, 1'b1, 32'h00030F0C);
    issue("se18_b", 2'b10, 18'b111111100011100011, 1'b1, 32'hFFFFE38C);
    issue("rsvd_a", 2'b11, 18'h2AAAA,              1'b1, 32'h00000000);
    issue("rsvd_b", 2'b00, 18'h00001,              1'b1, 32'h00000001);
    issue("hold",   2'b10, 18'h20000,              1'b1, 32'hFFF80000);
    issue("rst_mid", 2'b01, 18'h01000,             1'b0, 32'hFFFFF000);
    issue("rst_rel", 2'b01, 18'h01000,             1'b1, 32'hFFFFF000);
    issue("post_rst", 2'b11, 18'h00000,            1'b1, 32'h00000000);
    issue("post_rst2", 2'b00, 18'h0FFF,            1'b1, 32'h00000FFF);
    for (int k = 0; k < 300; k++) begin
      s  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) s = 2'b11;
      else if (s == 2'b11) s = 2'($urandom_range(0, 2));
      i  = 18'($urandom);
      rv = ($urandom_range(0, 39) != 0);
      issue_m("rand", s, i, rv);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/extend.md
EXTEND -- requirements
Module: extend

Interface
REQ-001 Parameter INSTR_W, default 18, immediate field width; only 18 is required to be supported.
REQ-002 Parameter DATA_W, default 32, extended output width; only 32 is required to be supported.
REQ-003 Port clk, input, 1, single clock for all registered state.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port ImmSrc, input, 2, extension mode select.
REQ-006 Port Instr, input, INSTR_W, instruction immediate field Instr[17:0].
REQ-007 Port ExtImm, output, DATA_W, combinational extended immediate.
REQ-008 Port ImmErr, output, 1, combinational flag, high when ImmSrc=2'b11.
REQ-009 Port ErrSticky, output, 1, registered flag, set on any sampled ImmErr.
REQ-010 Port ExtImmQ, output, DATA_W, registered copy of ExtImm; present only with EXTEND_REG_EN.

Function
REQ-011 ImmSrc=2'b00 SHALL give ExtImm = zero-extension of Instr[12:0]; Instr[17:13] ignored.
REQ-012 ImmSrc=2'b01 SHALL give ExtImm = sign-extension of Instr[12:0], sign bit Instr[12]; Instr[17:13] ignored.
REQ-013 ImmSrc=2'b10 SHALL give ExtImm = sign-extension of {Instr[17:0], 2'b00} to 32 bits, sign bit Instr[17].
REQ-014 ImmSrc=2'b11 SHALL give ExtImm = 32'h0 and ImmErr=1; ImmErr=0 in all other modes.
REQ-015 ExtImm and ImmErr SHALL be purely combinational, zero-cycle latency, independent of clk and rst_n.
REQ-016 X/Z on ImmSrc SHALL NOT be masked; no latches on any path.
REQ-017 ErrSticky SHALL set on the rising clk edge where ImmErr=1 and hold until reset.
REQ-018 ExtImmQ SHALL update to ExtImm on every rising clk edge, one-cycle latency.

Reset
REQ-019 rst_n low SHALL immediately clear ErrSticky to 0 and ExtImmQ to 32'h0, regardless of clk.
REQ-020 Reset SHALL NOT affect ExtImm or ImmErr.
REQ-021 Reset deassertion mid-operation: first capture on the first rising clk edge with rst_n high.

Configuration
REQ-022 Macro EXTEND_REG_EN defined: ExtImmQ port and register present per REQ-018/019.
REQ-023 Macro EXTEND_REG_EN undefined: ExtImmQ port and register omitted; all other behaviour unchanged.

Structure
REQ-024 Shared package extend_pkg SHALL hold the ImmSrc encoding enum (IMM_ZE13=00, IMM_SE13=01, IMM_SE18S2=10, IMM_RSVD=11) and width constants 18/32.
REQ-025 Combinational decode SHALL live in sub-module extend_core (ImmSrc, Instr -> ExtImm, ImmErr); top module extend adds registers.

Verification
REQ-026 ImmSrc=00, Instr=18'b111100001111000011 -> ExtImm=32'h000003C3, ImmErr=0; Instr=18'h3FFFF -> ExtImm=32'h00001FFF.
REQ-027 ImmSrc=01, Instr=18'b111100001111000011 -> ExtImm=32'h000003C3; Instr=18'h3FFFF -> ExtImm=32'hFFFFFFFF.
REQ-028 ImmSrc=10, Instr=18'b001100001111000011 -> ExtImm=32'h00030F0C; Instr=18'b111111100011100011 -> ExtImm=32'hFFFFE38C.
REQ-029 ImmSrc=11, any Instr -> ExtImm=32'h0, ImmErr=1; after one clk edge ErrSticky=1; returning to ImmSrc=00 keeps ErrSticky=1.
REQ-030 Assert rst_n=0 between clk edges -> ErrSticky=0 and ExtImmQ=0 immediately; ExtImm unchanged.
REQ-031 With EXTEND_REG_EN: ImmSrc=01, Instr=18'h3FFFF -> ExtImmQ=32'hFFFFFFFF one clk edge later, not before.
